serial_tx_arbiter: RTL and testbench

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_arbiter.sv | 117 +++++++++++
 tb/tb_serial_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Two-port word arbiter in front of a serial transmitter: bounded-burst fairness,
// one send per transmitter busy window, and a watchdog for a transmitter that never goes busy.
module serial_tx_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned WD_CYCLES = 4
) (
    input  logic        clock,
    input  logic        extReset,
    input  logic        req0_send,
    input  logic [31:0] req0_data,
    input  logic [3:0]  req0_valid,
    output logic        req0_ack,
    input  logic        req1_send,
    input  logic [31:0] req1_data,
    input  logic [3:0]  req1_valid,
    output logic        req1_ack,
    output logic        tx_send,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_valid,
    input  logic        tx_busy,
    output logic        owner,
    output logic        arb_idle,
    output logic        wd_error
);
    localparam int unsigned WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [7:0]      burst_q, burst_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      valid_q, valid_d;
    logic            wd_err_q, wd_err_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            keep;
    logic            win;

    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b1;
            burst_q  <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            wd_err_q <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wd_err_q <= wd_err_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wd_err_d = wd_err_q;
        wd_d     = wd_q;

        // burst_q==0 means no prior owner, so a tie flips the reset owner (1) to port 0
        keep = (burst_q != '0) && (burst_q < 8'(MAX_BURST));
        if (req0_send && req1_send) win = keep ? owner_q : ~owner_q;
        else                        win = req1_send;

        unique case (state_q)
            IDLE: begin
                if (!tx_busy && (req0_send || req1_send)) begin
                    state_d = ISSUE;
                    owner_d = win;
                    data_d  = win ? req1_data  : req0_data;
                    valid_d = win ? req1_valid : req0_valid;
                    if (win != owner_q || !(win ? req0_send : req1_send))
                        burst_d = 8'd1;
                    else if (burst_q < 8'(MAX_BURST))
                        burst_d = burst_q + 8'd1;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                wd_d    = '0;
            end
            WAIT_BUSY: begin
                // Watchdog counts WAIT_BUSY cycles only; the ISSUE cycle never sees busy
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wd_q == WD_W'(WD_CYCLES - 1)) begin
                    wd_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_send  = (state_q == ISSUE);
    assign req0_ack = tx_send && !owner_q;
    assign req1_ack = tx_send &&  owner_q;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign owner    = owner_q;
    assign arb_idle = (state_q == IDLE);
    assign wd_error = wd_err_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios then randomized traffic, every cycle
// checked against a transaction-level model of the arbitration and timing rules.
module tb_serial_tx_arbiter;
    localparam int MB = 2;
    localparam int WD = 4;

    logic        clock = 1'b0;
    logic        extReset;
    logic        req0_send, req1_send, tx_busy;
    logic [31:0] req0_data, req1_data;
    logic [3:0]  req0_valid, req1_valid;
    logic        req0_ack, req1_ack, tx_send, owner, arb_idle, wd_error;
    logic [31:0] tx_data;
    logic [3:0]  tx_valid;

    serial_tx_arbiter #(.MAX_BURST(MB), .WD_CYCLES(WD)) dut (
        .clock(clock), .extReset(extReset),
        .req0_send(req0_send), .req0_data(req0_data), .req0_valid(req0_valid), .req0_ack(req0_ack),
        .req1_send(req1_send), .req1_data(req1_data), .req1_valid(req1_valid), .req1_ack(req1_ack),
        .tx_send(tx_send), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .owner(owner), .arb_idle(arb_idle), .wd_error(wd_error)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int cyc = 0, earliest = 0, wd_at = -1, run = 0;
    int busy_left = 0, pend = 0, tx_len = 2, acks0 = 0;
    bit has_owner = 0, own = 0, exp_wd = 0, rand_tx = 0, sent = 0;
    logic [31:0] last_d = '0;
    logic [3:0]  last_v = '0;
    int mode [2];
    int grants [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit on);
        logic [31:0] d;
        logic [3:0]  v;
        d = $urandom;
        v = 4'($urandom);
        if (p == 0) begin req0_send = on; req0_data = d; req0_valid = v; end
        else        begin req1_send = on; req1_data = d; req1_valid = v; end
    endtask

    // mode 0: single word then drop; 1: continuous; 2: random requester
    task automatic upd_req(input int p, input bit acked);
        bit s;
        s = (p == 0) ? req0_send : req1_send;
        case (mode[p])
            0: if (acked) set_req(p, 0);
            1: if (acked) set_req(p, 1);
            default: begin
                if (acked)  set_req(p, ($urandom % 4) != 0);
                else if (s) begin if (($urandom % 16) == 0) set_req(p, 0); end
                else if (($urandom % 3) == 0) set_req(p, 1);
            end
        endcase
    endtask

    task automatic step();
        bit es, w, r0, r1, exp_idle;
        es = 0; w = 0;
        @(negedge clock);
        cyc++;
        r0 = req0_send; r1 = req1_send;
        if (extReset) begin
            chk("rst_send", 32'(tx_send), 0);
            chk("rst_data", tx_data, 0);
            chk("rst_valid", 32'(tx_valid), 0);
            chk("rst_ack0", 32'(req0_ack), 0);
            chk("rst_ack1", 32'(req1_ack), 0);
            chk("rst_owner", 32'(owner), 1);
            chk("rst_wd", 32'(wd_error), 0);
            chk("rst_idle", 32'(arb_idle), 1);
            earliest = cyc + 1; has_owner = 0; run = 0; exp_wd = 0; wd_at = -1;
            last_d = '0; last_v = '0;
        end else begin
            es = (cyc >= earliest) && (r0 || r1) && !tx_busy;
            exp_idle = !es && (cyc >= earliest - 1);
            if (es) begin
                if (r0 && !r1)      w = 0;
                else if (r1 && !r0) w = 1;
                else if (!has_owner) w = 0;
                else if (run < MB)   w = own;
                else                 w = !own;
                if (!has_owner || w != own || !(w ? r0 : r1)) run = 1;
                else if (run < MB) run++;
                own = w; has_owner = 1;
                last_d = w ? req1_data : req0_data;
                last_v = w ? req1_valid : req0_valid;
                earliest = (tx_len == 0) ? cyc + WD + 2 : cyc + tx_len + 3;
                wd_at    = (tx_len == 0) ? cyc + WD + 1 : -1;
            end
            if (cyc == wd_at) exp_wd = 1;
            chk("tx_send", 32'(tx_send), 32'(es));
            chk("ack0", 32'(req0_ack), 32'(es && !w));
            chk("ack1", 32'(req1_ack), 32'(es && w));
            chk("arb_idle", 32'(arb_idle), 32'(exp_idle));
            chk("tx_data", tx_data, last_d);
            chk("tx_valid", 32'(tx_valid), 32'(last_v));
            chk("owner", 32'(owner), has_owner ? 32'(own) : 1);
            chk("wd_error", 32'(wd_error), 32'(exp_wd));
            if (req0_ack === 1'b1) begin grants.push_back(0); acks0++; end
            if (req1_ack === 1'b1) grants.push_back(1);
        end
        sent = es;
        // transmitter: busy from the cycle after the send, for tx_len cycles
        if (es && tx_len > 0) pend = tx_len;
        else if (pend > 0) begin busy_left = pend; pend = 0; end
        else if (busy_left > 0) busy_left--;
        tx_busy = (busy_left > 0);
        if (es && rand_tx) tx_len = (($urandom % 8) == 0) ? 0 : 1 + int'($urandom % 4);
        upd_req(0, es && !w);
        upd_req(1, es && w);
    endtask

    task automatic wait_send(input string tag, input int bound);
        bit got;
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            got = (tx_send === 1'b1);
        end
        tests++;
        assert (got) else begin
            fails++;
            $error("FAIL %s: observed no tx_send within %0d cycles, expected one", tag, bound);
        end
    endtask

    initial begin
        int exp_order [6] = '{0, 0, 1, 1, 0, 0};
        int t0, t1, n_sends, a0;
        bit seen;

        extReset = 1; tx_busy = 0;
        req0_send = 0; req0_data = '0; req0_valid = '0;
        req1_send = 0; req1_data = '0; req1_valid = '0;
        mode[0] = 0; mode[1] = 0;
        repeat (3) step();
        extReset = 0;

        // Contention with MAX_BURST=2
        mode[0] = 1; mode[1] = 1;
        set_req(0, 1); set_req(1, 1);
        grants.delete();
        for (int i = 0; i < 200 && grants.size() < 6; i++) step();
        chk("grant_count", 32'(grants.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < grants.size()) chk($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        mode[0] = 0; mode[1] = 0;
        repeat (20) step();

        // Single word from port 1
        req1_send = 1; req1_data = 32'h534C4131; req1_valid = 4'hF;
        wait_send("single", 10);
        chk("single_data", tx_data, 32'h534C4131);
        chk("single_valid", 32'(tx_valid), 32'hF);
        chk("single_ack1", 32'(req1_ack), 1);
        chk("single_owner", 32'(owner), 1);
        repeat (6) step();

        // Long busy: nothing issues until the transmitter is done
        tx_len = 1000;
        set_req(0, 1);
        wait_send("hold_first", 10);
        t0 = cyc;
        set_req(1, 1);
        n_sends = 0;
        repeat (1000) begin step(); n_sends += int'(tx_send === 1'b1); end
        chk("hold_quiet", 32'(n_sends), 0);
        tx_len = 2;
        wait_send("hold_release", 10);
        chk("hold_gap", 32'(cyc - t0), 1003);
        repeat (6) step();

        // Watchdog: transmitter never goes busy
        tx_len = 0;
        set_req(0, 1);
        wait_send("wd_first", 10);
        t0 = cyc;
        tx_len = 2;
        set_req(1, 1);
        seen = 0; t1 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (wd_error === 1'b1) begin seen = 1; t1 = cyc; end
        end
        chk("wd_delay", 32'(t1 - t0), 32'(WD + 1));
        wait_send("wd_next", 10);
        chk("wd_next_ack1", 32'(req1_ack), 1);
        chk("wd_sticky", 32'(wd_error), 1);
        repeat (6) step();

        // Dropped request while busy
        tx_len = 10;
        set_req(1, 1);
        wait_send("drop_first", 10);
        repeat (3) step();
        a0 = acks0;
        set_req(0, 1);
        step();
        set_req(0, 0);
        n_sends = 0;
        repeat (15) begin step(); n_sends += int'(tx_send === 1'b1); end
        chk("drop_ack", 32'(acks0 - a0), 0);
        chk("drop_send", 32'(n_sends), 0);

        // Reset while in WAIT_DONE, then a fresh tie goes to port 0
        tx_len = 20;
        set_req(0, 1); set_req(1, 1);
        wait_send("rst_first", 10);
        repeat (4) step();
        extReset = 1;
        repeat (2) step();
        set_req(0, 1); set_req(1, 1);
        extReset = 0;
        tx_len = 2;
        wait_send("rst_next", 40);
        chk("rst_tie_ack0", 32'(req0_ack), 1);
        chk("rst_tie_owner", 32'(owner), 0);
        repeat (6) step();

        // Randomized traffic with random transmitter lengths, including watchdog cases
        mode[0] = 2; mode[1] = 2; rand_tx = 1;
        repeat (1500) step();
        extReset = 1;
        step();
        extReset = 0;
        repeat (1500) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
